// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller.
// State encoding, money widths and the coin value table.
package vend_pkg;

    localparam int unsigned MONEY_W = 13;
    localparam int unsigned ITEM_W  = 2;

    localparam logic [MONEY_W-1:0] COIN_5C   = 13'd5;
    localparam logic [MONEY_W-1:0] COIN_10C  = 13'd10;
    localparam logic [MONEY_W-1:0] COIN_25C  = 13'd25;
    localparam logic [MONEY_W-1:0] COIN_100C = 13'd100;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDispense,
        StChange
    } vend_state_e;

    function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] coin_type);
        logic [MONEY_W-1:0] value;
        case (coin_type)
            2'd0:    value = COIN_5C;
            2'd1:    value = COIN_10C;
            2'd2:    value = COIN_25C;
            default: value = COIN_100C;
        endcase
        return value;
    endfunction

endpackage

// File: rtl/vend_change_calc.sv
// Price table lookup, credit >= price compare and credit - price subtract.
// Purely combinational; the controller supplies both operands.
module vend_change_calc
    import vend_pkg::*;
#(
    parameter logic [MONEY_W-1:0] PRICE0 = 13'd75,
    parameter logic [MONEY_W-1:0] PRICE1 = 13'd100,
    parameter logic [MONEY_W-1:0] PRICE2 = 13'd125,
    parameter logic [MONEY_W-1:0] PRICE3 = 13'd150
) (
    input  logic [ITEM_W-1:0]  item,
    input  logic [MONEY_W-1:0] money,
    input  logic [MONEY_W-1:0] price_op,
    output logic [MONEY_W-1:0] price,
    output logic [MONEY_W-1:0] diff,
    output logic               enough
);

    always_comb begin
        case (item)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            default: price = PRICE3;
        endcase
    end

    assign diff   = money - price_op;
    assign enough = (money >= price_op);

endmodule

// File: rtl/vend_controller.sv
// Vending machine sequencing FSM: credit, selection, dispense and change handshakes.
// Define VEND_TIMEOUT_EN to auto-refund after TIMEOUT_CYC idle cycles in COLLECT.
module vend_controller
    import vend_pkg::*;
#(
    parameter logic [MONEY_W-1:0] PRICE0     = 13'd75,
    parameter logic [MONEY_W-1:0] PRICE1     = 13'd100,
    parameter logic [MONEY_W-1:0] PRICE2     = 13'd125,
    parameter logic [MONEY_W-1:0] PRICE3     = 13'd150,
    parameter logic [MONEY_W-1:0] MAX_CREDIT = 13'd1000
`ifdef VEND_TIMEOUT_EN
    ,
    parameter logic [23:0]        TIMEOUT_CYC = 24'd10_000_000
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               coin_valid,
    input  logic [1:0]         coin_type,
    output logic               coin_reject,
    input  logic               sel_valid,
    input  logic [ITEM_W-1:0]  sel_item,
    input  logic               cancel,
    output logic [MONEY_W-1:0] credit,
    output logic               err_insufficient,
    output logic               dispense_valid,
    output logic [ITEM_W-1:0]  dispense_item,
    input  logic               dispense_ready,
    output logic               change_valid,
    output logic [MONEY_W-1:0] change_amount,
    input  logic               change_ready,
    output logic               busy
);

    vend_state_e        state_q;
    logic [MONEY_W-1:0] price_q;

    logic [MONEY_W-1:0] coin_val;
    logic [MONEY_W-1:0] credit_sum;
    logic               coin_fits;
    logic [MONEY_W-1:0] credit_acc;
    logic [MONEY_W-1:0] price_lut;
    logic [MONEY_W-1:0] price_op;
    logic [MONEY_W-1:0] diff;
    logic               enough;
    logic               timeout;
    logic               abort;

    assign coin_val   = coin_value(coin_type);
    assign credit_sum = credit + coin_val;
    assign coin_fits  = (credit_sum <= MAX_CREDIT);
    // Credit including a coin accepted this cycle, so a refund never loses it.
    assign credit_acc = (coin_valid && coin_fits) ? credit_sum : credit;
    assign price_op   = (state_q == StDispense) ? price_q : price_lut;

    vend_change_calc #(
        .PRICE0 (PRICE0),
        .PRICE1 (PRICE1),
        .PRICE2 (PRICE2),
        .PRICE3 (PRICE3)
    ) u_calc (
        .item     (sel_item),
        .money    (credit),
        .price_op (price_op),
        .price    (price_lut),
        .diff     (diff),
        .enough   (enough)
    );

`ifdef VEND_TIMEOUT_EN
    logic [23:0] idle_q;
    logic        activity;

    assign activity = coin_valid || sel_valid || cancel;
    assign timeout  = (state_q == StCollect) && !activity && (idle_q == TIMEOUT_CYC - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (state_q != StCollect || activity) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_q + 24'd1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign abort = cancel || timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            price_q          <= '0;
            credit           <= '0;
            change_amount    <= '0;
            dispense_item    <= '0;
            coin_reject      <= 1'b0;
            err_insufficient <= 1'b0;
            dispense_valid   <= 1'b0;
            change_valid     <= 1'b0;
            busy             <= 1'b0;
        end else begin
            coin_reject      <= 1'b0;
            err_insufficient <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (coin_valid) begin
                        credit  <= coin_val;
                        state_q <= StCollect;
                    end
                    if (sel_valid) begin
                        err_insufficient <= 1'b1;
                    end
                end
                StCollect: begin
                    if (coin_valid) begin
                        if (coin_fits) begin
                            credit <= credit_sum;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                    if (abort) begin
                        change_amount <= credit_acc;
                        change_valid  <= 1'b1;
                        busy          <= 1'b1;
                        state_q       <= StChange;
                    end else if (sel_valid) begin
                        if (enough) begin
                            dispense_item  <= sel_item;
                            price_q        <= price_lut;
                            dispense_valid <= 1'b1;
                            busy           <= 1'b1;
                            state_q        <= StDispense;
                        end else begin
                            err_insufficient <= 1'b1;
                        end
                    end
                end
                StDispense: begin
                    coin_reject <= coin_valid;
                    if (dispense_ready) begin
                        dispense_valid <= 1'b0;
                        credit         <= '0;
                        if (diff != '0) begin
                            change_amount <= diff;
                            change_valid  <= 1'b1;
                            state_q       <= StChange;
                        end else begin
                            busy    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                StChange: begin
                    coin_reject <= coin_valid;
                    if (change_ready) begin
                        change_valid  <= 1'b0;
                        change_amount <= '0;
                        credit        <= '0;
                        busy          <= 1'b0;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios then random transactions
// checked against a transaction-level credit/change model.
module tb_vend_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        coin_valid = 1'b0;
    logic [1:0]  coin_type = 2'd0;
    logic        coin_reject;
    logic        sel_valid = 1'b0;
    logic [1:0]  sel_item = 2'd0;
    logic        cancel = 1'b0;
    logic [12:0] credit;
    logic        err_insufficient;
    logic        dispense_valid;
    logic [1:0]  dispense_item;
    logic        dispense_ready = 1'b0;
    logic        change_valid;
    logic [12:0] change_amount;
    logic        change_ready = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

`ifdef VEND_TIMEOUT_EN
    vend_controller #(.TIMEOUT_CYC (24'd20)) dut (
`else
    vend_controller dut (
`endif
        .clk              (clk),
        .rst_n            (rst_n),
        .coin_valid       (coin_valid),
        .coin_type        (coin_type),
        .coin_reject      (coin_reject),
        .sel_valid        (sel_valid),
        .sel_item         (sel_item),
        .cancel           (cancel),
        .credit           (credit),
        .err_insufficient (err_insufficient),
        .dispense_valid   (dispense_valid),
        .dispense_item    (dispense_item),
        .dispense_ready   (dispense_ready),
        .change_valid     (change_valid),
        .change_amount    (change_amount),
        .change_ready     (change_ready),
        .busy             (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model: credit held by the machine (0 means idle) and pending change.
    int m_credit = 0;
    int m_change = 0;
    int prices[4]     = '{75, 100, 125, 150};
    int coin_cents[4] = '{5, 10, 25, 100};
    localparam int MaxCredit = 1000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_credit"}, 32'(credit), 32'd0);
        check({tag, "_change_amount"}, 32'(change_amount), 32'd0);
        check({tag, "_change_valid"}, 32'(change_valid), 32'd0);
        check({tag, "_dispense_valid"}, 32'(dispense_valid), 32'd0);
        check({tag, "_dispense_item"}, 32'(dispense_item), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_coin_reject"}, 32'(coin_reject), 32'd0);
        check({tag, "_err"}, 32'(err_insufficient), 32'd0);
    endtask

    task automatic insert_coin(input int t);
        int  v;
        logic exp_rej;
        v = coin_cents[t];
        coin_valid = 1'b1;
        coin_type  = t[1:0];
        @(negedge clk);
        coin_valid = 1'b0;
        if (m_credit + v <= MaxCredit) begin
            m_credit += v;
            exp_rej = 1'b0;
        end else begin
            exp_rej = 1'b1;
        end
        check("coin_reject", 32'(coin_reject), 32'(exp_rej));
        check("coin_credit", 32'(credit), 32'(m_credit));
    endtask

    task automatic select(input int item, output bit vended);
        sel_valid = 1'b1;
        sel_item  = item[1:0];
        @(negedge clk);
        sel_valid = 1'b0;
        if (m_credit >= prices[item]) begin
            vended   = 1'b1;
            m_change = m_credit - prices[item];
            check("sel_dispense_valid", 32'(dispense_valid), 32'd1);
            check("sel_dispense_item", 32'(dispense_item), 32'(item));
            check("sel_busy", 32'(busy), 32'd1);
            check("sel_err", 32'(err_insufficient), 32'd0);
        end else begin
            vended = 1'b0;
            check("sel_err", 32'(err_insufficient), 32'd1);
            check("sel_no_dispense", 32'(dispense_valid), 32'd0);
            check("sel_credit", 32'(credit), 32'(m_credit));
        end
    endtask

    task automatic finish_vend(input int wait_cyc, input bit coin_during);
        for (int i = 0; i < wait_cyc; i++) begin
            if (coin_during && i == 0) begin
                coin_valid = 1'b1;
                coin_type  = 2'd3;
            end
            @(negedge clk);
            coin_valid = 1'b0;
            check("disp_hold_valid", 32'(dispense_valid), 32'd1);
            if (coin_during && i == 0) begin
                check("disp_coin_reject", 32'(coin_reject), 32'd1);
            end
        end
        dispense_ready = 1'b1;
        @(negedge clk);
        dispense_ready = 1'b0;
        m_credit = 0;
        check("disp_done_valid", 32'(dispense_valid), 32'd0);
        check("disp_change_valid", 32'(change_valid), 32'(m_change != 0));
        check("disp_change_amount", 32'(change_amount), 32'(m_change));
        check("disp_credit", 32'(credit), 32'd0);
        check("disp_busy", 32'(busy), 32'(m_change != 0));
    endtask

    task automatic take_change(input int wait_cyc);
        for (int i = 0; i < wait_cyc; i++) begin
            @(negedge clk);
            check("chg_hold_valid", 32'(change_valid), 32'd1);
            check("chg_hold_amount", 32'(change_amount), 32'(m_change));
        end
        change_ready = 1'b1;
        @(negedge clk);
        change_ready = 1'b0;
        m_change = 0;
        check("chg_done_valid", 32'(change_valid), 32'd0);
        check("chg_done_amount", 32'(change_amount), 32'd0);
        check("chg_done_credit", 32'(credit), 32'd0);
        check("chg_done_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_cancel(input bit with_sel, input int item, output bit went);
        cancel    = 1'b1;
        sel_valid = with_sel;
        sel_item  = item[1:0];
        @(negedge clk);
        cancel    = 1'b0;
        sel_valid = 1'b0;
        check("cancel_no_dispense", 32'(dispense_valid), 32'd0);
        if (m_credit > 0) begin
            went     = 1'b1;
            m_change = m_credit;
            m_credit = 0;
            check("cancel_change_valid", 32'(change_valid), 32'd1);
            check("cancel_change_amount", 32'(change_amount), 32'(m_change));
            check("cancel_busy", 32'(busy), 32'd1);
        end else begin
            went = 1'b0;
            check("cancel_idle_nochange", 32'(change_valid), 32'd0);
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit v;
        bit went;
        bit seen;
        int r;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Exact price: vend with no change handshake
        insert_coin(2); insert_coin(2); insert_coin(2);
        check("exact_credit75", 32'(credit), 32'd75);
        select(0, v);
        finish_vend(1, 1'b0);

        // Change of 25, hopper stalls three cycles
        insert_coin(3);
        select(0, v);
        finish_vend(0, 1'b0);
        take_change(3);

        // Insufficient credit then cancel
        insert_coin(1); insert_coin(2);
        select(1, v);
        do_cancel(1'b0, 0, went);
        take_change(1);

        // Selection while idle is always insufficient
        select(3, v);

        // Credit ceiling: exactly MAX accepted, one more coin rejected
        for (int i = 0; i < 10; i++) insert_coin(3);
        check("max_credit", 32'(credit), 32'd1000);
        insert_coin(0);
        do_cancel(1'b0, 0, went);
        take_change(0);

        // Coin during DISPENSE rejected
        insert_coin(3);
        select(1, v);
        finish_vend(2, 1'b1);

        // Cancel beats select; then reset in the middle of CHANGE
        insert_coin(3); insert_coin(2); insert_coin(2);
        do_cancel(1'b1, 3, went);
        check("cancel_wins_amount", 32'(change_amount), 32'd150);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        m_credit = 0;
        m_change = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Idle timeout behaviour
        insert_coin(1);
`ifdef VEND_TIMEOUT_EN
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = change_valid;
        end
        check("timeout_fired", 32'(seen), 32'd1);
        check("timeout_amount", 32'(change_amount), 32'd10);
        m_change = 10;
        m_credit = 0;
        take_change(0);
`else
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (change_valid) seen = 1'b1;
        end
        check("no_timeout", 32'(seen), 32'd0);
        check("no_timeout_credit", 32'(credit), 32'd10);
        do_cancel(1'b0, 0, went);
        take_change(0);
`endif

        // Random transactions against the model
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                insert_coin($urandom_range(0, 3));
            end else if (r < 8) begin
                select($urandom_range(0, 3), v);
                if (v) begin
                    finish_vend($urandom_range(0, 3), 1'($urandom_range(0, 1)));
                    if (m_change != 0) take_change($urandom_range(0, 3));
                end
            end else begin
                do_cancel(1'b0, 0, went);
                if (went) take_change($urandom_range(0, 3));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
